// File: rtl/fp_to_fixed_pipe.sv
// Three-stage IEEE-754 single to signed fixed-point converter with valid/ready on both sides.
// One global advance enable stalls every stage together, so ordering is preserved trivially.
module fp_to_fixed_pipe #(
   parameter int WORD_LENGTH = 21,
   parameter int FRAC_BITS   = 19
) (
   input  logic                   clk,
   input  logic                   reset,
   input  logic                   in_valid,
   output logic                   in_ready,
   input  logic [31:0]            in_data,
   input  logic                   in_round,
   output logic                   out_valid,
   input  logic                   out_ready,
   output logic [WORD_LENGTH-1:0] out_data,
   output logic                   out_ovf,
   output logic                   out_unf,
   output logic                   out_inv
);

   localparam int MAG_W = 64;
   localparam logic [MAG_W-1:0] POS_LIM = (64'd1 << (WORD_LENGTH - 1)) - 64'd1;
   localparam logic [MAG_W-1:0] NEG_LIM = 64'd1 << (WORD_LENGTH - 1);
   localparam logic signed [10:0] SH_OFF = 11'(FRAC_BITS - 150);
   localparam logic [WORD_LENGTH-1:0] SAT_POS = {1'b0, {(WORD_LENGTH-1){1'b1}}};
   localparam logic [WORD_LENGTH-1:0] SAT_NEG = {1'b1, {(WORD_LENGTH-1){1'b0}}};

   logic adv;

   logic        s1_valid_q, s1_valid_d, s1_sign_q, s1_sign_d, s1_round_q, s1_round_d;
   logic [7:0]  s1_exp_q, s1_exp_d;
   logic [22:0] s1_man_q, s1_man_d;
   logic        s1_zero_q, s1_zero_d, s1_inf_q, s1_inf_d, s1_nan_q, s1_nan_d;

   logic             s2_valid_q, s2_valid_d, s2_sign_q, s2_sign_d, s2_big_q, s2_big_d;
   logic [MAG_W-1:0] s2_mag_q, s2_mag_d;
   logic             s2_zero_q, s2_zero_d, s2_inf_q, s2_inf_d, s2_nan_q, s2_nan_d;

   logic                   out_valid_q, out_valid_d;
   logic [WORD_LENGTH-1:0] out_data_q, out_data_d;
   logic                   out_ovf_q, out_ovf_d, out_unf_q, out_unf_d, out_inv_q, out_inv_d;

   logic [23:0]            mant;
   logic signed [10:0]     sh, rsh;
   logic [49:0]            shifted;
   logic [MAG_W-1:0]       mag;
   logic                   guard, sticky, big;
   logic [WORD_LENGTH-1:0] signed_res;

   always_comb begin
      adv = !out_valid_q | out_ready;

      s1_valid_d = in_valid;
      s1_sign_d  = in_data[31];
      s1_exp_d   = in_data[30:23];
      s1_man_d   = in_data[22:0];
      s1_round_d = in_round;
      s1_zero_d  = (in_data[30:23] == 8'h00);
      s1_inf_d   = (in_data[30:23] == 8'hFF) && (in_data[22:0] == 23'd0);
      s1_nan_d   = (in_data[30:23] == 8'hFF) && (in_data[22:0] != 23'd0);

      mant    = {1'b1, s1_man_q};
      sh      = $signed({3'b000, s1_exp_q}) + SH_OFF;
      rsh     = -sh;
      mag     = '0;
      guard   = 1'b0;
      sticky  = 1'b0;
      big     = 1'b0;
      shifted = '0;
      // Left shifts past 40 cannot fit any legal word length, so flag them instead of shifting.
      if (!sh[10]) begin
         if (sh > 11'sd40) big = 1'b1;
         else              mag = {40'd0, mant} << sh[5:0];
      end else if (rsh < 11'sd26) begin
         shifted = {mant, 26'd0} >> rsh[4:0];
         mag     = {40'd0, shifted[49:26]};
         guard   = shifted[25];
         sticky  = |shifted[24:0];
      end
      s2_valid_d = s1_valid_q;
      s2_sign_d  = s1_sign_q;
      s2_big_d   = big;
      s2_mag_d   = mag + 64'(s1_round_q & guard & (sticky | mag[0]));
      s2_zero_d  = s1_zero_q;
      s2_inf_d   = s1_inf_q;
      s2_nan_d   = s1_nan_q;

      // The exact negative minimum is representable, hence the asymmetric limits.
      out_valid_d = s2_valid_q;
      out_inv_d   = s2_nan_q;
      out_ovf_d   = !s2_nan_q && !s2_zero_q &&
                    (s2_inf_q || s2_big_q || (s2_sign_q ? (s2_mag_q > NEG_LIM) : (s2_mag_q > POS_LIM)));
      signed_res  = s2_sign_q ? -s2_mag_q[WORD_LENGTH-1:0] : s2_mag_q[WORD_LENGTH-1:0];
      if (s2_nan_q || s2_zero_q) out_data_d = '0;
      else if (out_ovf_d)        out_data_d = s2_sign_q ? SAT_NEG : SAT_POS;
      else                       out_data_d = signed_res;
      out_unf_d = !s2_nan_q && !s2_zero_q && !s2_inf_q && !out_ovf_d && (s2_mag_q == '0);
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         s1_valid_q  <= 1'b0;
         s2_valid_q  <= 1'b0;
         out_valid_q <= 1'b0;
         out_data_q  <= '0;
         out_ovf_q   <= 1'b0;
         out_unf_q   <= 1'b0;
         out_inv_q   <= 1'b0;
      end else if (adv) begin
         s1_valid_q  <= s1_valid_d;
         s1_sign_q   <= s1_sign_d;
         s1_exp_q    <= s1_exp_d;
         s1_man_q    <= s1_man_d;
         s1_round_q  <= s1_round_d;
         s1_zero_q   <= s1_zero_d;
         s1_inf_q    <= s1_inf_d;
         s1_nan_q    <= s1_nan_d;
         s2_valid_q  <= s2_valid_d;
         s2_sign_q   <= s2_sign_d;
         s2_big_q    <= s2_big_d;
         s2_mag_q    <= s2_mag_d;
         s2_zero_q   <= s2_zero_d;
         s2_inf_q    <= s2_inf_d;
         s2_nan_q    <= s2_nan_d;
         out_valid_q <= out_valid_d;
         out_data_q  <= out_data_d;
         out_ovf_q   <= out_ovf_d;
         out_unf_q   <= out_unf_d;
         out_inv_q   <= out_inv_d;
      end
   end

   assign in_ready  = adv;
   assign out_valid = out_valid_q;
   assign out_data  = out_data_q;
   assign out_ovf   = out_ovf_q;
   assign out_unf   = out_unf_q;
   assign out_inv   = out_inv_q;

endmodule

// File: doc/fp_to_fixed_pipe.md
Name: fp_to_fixed_pipe

Overview:
Pipelined, parametrised IEEE-754 single-precision to signed two's-complement fixed-point converter with valid/ready handshaking on both sides. It supersedes the combinational converter and adds:
- arbitrary Q-format (total width and fraction bits);
- left and right shifts across the full exponent range;
- selectable rounding, saturation and status flags.
It sits between the float datapath and the fixed-point accelerator, one conversion per cycle at full throughput.

Parameters:
WORD_LENGTH, 21, total output width including sign bit (valid range 4..32).
FRAC_BITS, 19, number of fractional bits in the output (0..WORD_LENGTH-2).

Ports:
clk  in  1  clock; all state updates on rising edge.
reset  in  1  synchronous, active-high reset.
in_valid  in  1  input sample valid.
in_ready  out  1  converter can accept a sample this cycle.
in_data  in  32  IEEE-754 single-precision input.
in_round  in  1  rounding mode for this sample: 0 = truncate toward zero, 1 = round-to-nearest ties-to-even.
out_valid  out  1  out_data/flags valid.
out_ready  in  1  downstream accepts the output this cycle.
out_data  out  WORD_LENGTH  signed fixed-point result, value = out_data * 2^-FRAC_BITS.
out_ovf  out  1  result saturated (magnitude too large or infinity).
out_unf  out  1  nonzero finite input produced result 0.
out_inv  out  1  input was NaN.

Behaviour:
- Reset (synchronous, clk edge with reset=1):
  - all stage valid bits clear;
  - out_valid=0, out_data=0, out_ovf=out_unf=out_inv=0;
  - in_ready=1 in the first cycle after reset.
- Reset mid-operation discards every in-flight sample; no partial output appears.
- Pipeline: 3 register stages; latency 3 cycles from input handshake to out_valid with no stall.
  - S1: unpack sign/exponent/mantissa; classify zero/denormal/inf/NaN; latch in_round.
  - S2: shift and round the magnitude.
  - S3: negate, saturate, register outputs.
- Stall rule: global advance enable adv = !out_valid | out_ready; in_ready = adv.
  - Input accepted when in_valid & in_ready.
  - When adv=0, every stage holds. out_data and flags stay stable while out_valid=1 and out_ready=0.
  - Bubbles propagate as stage valid=0.
- Sample order preserved; no sample dropped or duplicated.
- Arithmetic:
  - mant = {1, in[22:0]} for exponent in 1..254.
  - sh = exponent - 127 + FRAC_BITS - 23, signed.
  - sh >= 0: mag = mant << sh, computed wide enough to detect overflow; mag beyond 2^(WORD_LENGTH-1) forces saturation.
  - sh < 0: mag = mant >> -sh; guard = first discarded bit, sticky = OR of the rest.
  - -sh >= 26: mag=0, guard=sticky=0, but the input is still treated as nonzero for unf.
- Rounding:
  - truncate: mag unchanged.
  - RNE: mag += guard & (sticky | mag[0]).
- Sign and saturation:
  - Negative: result = -mag.
  - Saturate positive to 2^(WORD_LENGTH-1)-1 and negative to -2^(WORD_LENGTH-1). The exact negative minimum is not an overflow.
  - out_ovf=1 whenever clamping occurs.
- Special inputs:
  - exponent 0 (zero/denormal): result 0, no flags (denormals flushed, unf=0).
  - exponent 255, mantissa 0 (±inf): saturate by sign, ovf=1.
  - exponent 255, mantissa ≠ 0 (NaN): result 0, inv=1, ovf=unf=0.
- out_unf = 1 iff input finite, normal, and final result 0.
- Flags are per-sample and travel with the data; they are not sticky across samples.

Test Plan (defaults WORD_LENGTH=21, FRAC_BITS=19; out_ready=1 unless stated):
1. Basic values, back-to-back, one per cycle: 0x3F800000 -> 0x080000; 0xBF800000 -> 0x180000; 0x3F400000 -> 0x060000. Each appears 3 cycles after acceptance; all flags 0.
2. Saturation and specials:
   - 0x40400000 (3.0) -> 0x0FFFFF, ovf=1.
   - 0xC0000000 (-2.0) -> 0x100000, ovf=0.
   - 0xFF800000 (-inf) -> 0x100000, ovf=1.
   - 0x7FC00000 (NaN) -> 0, inv=1.
   - 0x00000001 -> 0, no flags.
3. Rounding, each input run with in_round=0 then 1:
   - 0x35C00000 (0.75 LSB) -> 0 with unf=1 / 0x000001.
   - 0x36400000 (1.5 LSB) -> 0x000001 / 0x000002.
   - 0x35800000 (0.5 LSB tie) -> 0 with unf=1 in both modes.
   - 0x00800000 (-sh ≥ 26) -> 0, unf=1.
4. Backpressure:
   - Send 4 samples with out_ready=0 from cycle 0: first output appears; in_ready drops once the pipeline is full; out_data is held stable ≥5 cycles.
   - Raise out_ready: all 4 results delivered in order, one per cycle, none lost.
5. Random bubbles: randomise in_valid/out_ready over 10k random floats. Results must match a reference model bit-exactly, including flags and order.
6. Reset mid-stream: assert reset for 1 cycle with 3 samples in flight -> next cycle out_valid=0, out_data=0, flags 0, in_ready=1; none of the flushed samples ever emerges.
